// File: rtl/fir_run_sequencer.sv
// Run controller: button debounce, sample tick, calculation sequencing, display paging.
// Define FIR_SEQ_WATCHDOG_EN to abort stalled handshakes and flag err.
module fir_run_sequencer #(
  parameter int SAMPLE_DIV   = 50000000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int PAGE_DIV     = 25000000,
  parameter int CNT_W        = 36,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             toggle_btn,
  output logic             run,
  output logic             rng_step,
  output logic             filt_load,
  input  logic             filt_done,
  output logic             bcd_start,
  input  logic             bcd_done,
  output logic             busy,
  output logic [CNT_W-1:0] calc_count,
  output logic [1:0]       page_sel,
  output logic             page_tick,
  output logic             overrun,
  output logic             err
);
  localparam int SW = $clog2(SAMPLE_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PW = $clog2(PAGE_DIV + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PAGE_DIV - 1);

  if (SAMPLE_DIV < 2 || PAGE_DIV < 2 || DEBOUNCE_CYC < 1 ||
      TIMEOUT_CYC < 1 || CNT_W < 1) begin : g_bad_param
    $error("fir_run_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_LOAD, S_WAIT_F, S_CONV, S_WAIT_B
  } state_e;

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [DW-1:0] deb_q;
  logic          run_q, run_d, start;
  logic [SW-1:0] pre_q;
  logic          tick_q;
  state_e        state_q;
  logic          rng_q, load_q, bcd_q, busy_q, ovr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0] pg_cnt_q;
  logic [1:0]    page_q;
  logic          ptick_q;

  // Synchronizer and accepted level rest at the released (high) level.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      deb_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= toggle_btn;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        deb_q <= '0;
      end else if (deb_q == D_LAST) begin
        deb_q   <= '0;
        level_q <= sync2_q;
        press_q <= ~sync2_q;
      end else begin
        deb_q <= deb_q + 1'b1;
      end
    end
  end

  assign run_d = run_q ^ press_q;
  assign start = press_q & ~run_q;

  // The stop edge itself is excluded so no tick escapes after run falls.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      tick_q <= 1'b0;
      if (start) begin
        pre_q <= '0;
      end else if (run_q && !press_q) begin
        if (pre_q == S_LAST) begin
          pre_q  <= '0;
          tick_q <= 1'b1;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

`ifdef FIR_SEQ_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wd_q;
  logic          wd_fire;
  logic          err_q;

  assign wd_fire = (wd_q == T_LAST);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (state_q == S_WAIT_F || state_q == S_WAIT_B) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rng_q   <= 1'b0;
      load_q  <= 1'b0;
      bcd_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef FIR_SEQ_WATCHDOG_EN
      err_q   <= 1'b0;
`endif
    end else begin
      rng_q  <= 1'b0;
      load_q <= 1'b0;
      bcd_q  <= 1'b0;
      if (tick_q && state_q != S_IDLE) begin
        ovr_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (tick_q) begin
            state_q <= S_STEP;
            rng_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_STEP: begin
          state_q <= S_LOAD;
          load_q  <= 1'b1;
        end
        S_LOAD: state_q <= S_WAIT_F;
        S_WAIT_F: begin
          if (filt_done) begin
            state_q <= S_CONV;
            bcd_q   <= 1'b1;
          end
`ifdef FIR_SEQ_WATCHDOG_EN
          else if (wd_fire) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
`endif
        end
        S_CONV: state_q <= S_WAIT_B;
        S_WAIT_B: begin
          if (bcd_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
          end
`ifdef FIR_SEQ_WATCHDOG_EN
          else if (wd_fire) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
      if (start) begin
        cnt_q <= '0;
        ovr_q <= 1'b0;
`ifdef FIR_SEQ_WATCHDOG_EN
        err_q <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pg_cnt_q <= '0;
      page_q   <= 2'd0;
      ptick_q  <= 1'b0;
    end else if (pg_cnt_q == P_LAST) begin
      pg_cnt_q <= '0;
      page_q   <= page_q + 2'd1;
      ptick_q  <= 1'b1;
    end else begin
      pg_cnt_q <= pg_cnt_q + 1'b1;
      ptick_q  <= 1'b0;
    end
  end

  assign run        = run_q;
  assign rng_step   = rng_q;
  assign filt_load  = load_q;
  assign bcd_start  = bcd_q;
  assign busy       = busy_q;
  assign calc_count = cnt_q;
  assign page_sel   = page_q;
  assign page_tick  = ptick_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_fir_run_sequencer.sv
// Directed bench for fir_run_sequencer: button, sequencing, overrun, stop, paging, watchdog, wrap.
// Cycle numbers count from reset release; a 5-cycle press at cycle p raises run at p+7.
module tb_fir_run_sequencer;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b1;
  logic filt_done = 1'b0;
  logic bcd_done = 1'b0;
  logic run, rng_step, filt_load, bcd_start, busy;
  logic [CNT_W-1:0] calc_count;
  logic [1:0] page_sel;
  logic page_tick, overrun, err;

  always #5 clk = ~clk;

  fir_run_sequencer #(
    .SAMPLE_DIV(8), .DEBOUNCE_CYC(4), .PAGE_DIV(16),
    .CNT_W(CNT_W), .TIMEOUT_CYC(32)
  ) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .toggle_btn(btn),
    .run(run), .rng_step(rng_step), .filt_load(filt_load),
    .filt_done(filt_done), .bcd_start(bcd_start),
    .bcd_done(bcd_done), .busy(busy), .calc_count(calc_count),
    .page_sel(page_sel), .page_tick(page_tick),
    .overrun(overrun), .err(err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc, fl_at, bs_at, rise_at, fall_at, err_at;
  int rng_q[$], load_q[$], bst_q[$], idle_q[$];
  int ptk_q[$], psel_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn = 1'b1;
    filt_done = 1'b0;
    bcd_done = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0; fl_at = -1000; bs_at = -1000;
    rise_at = -1; fall_at = -1; err_at = -1;
    rng_q.delete(); load_q.delete(); bst_q.delete();
    idle_q.delete(); ptk_q.delete(); psel_q.delete();
  endtask

  // fd/bd: done delay after load/start (-1 = never); pat/plen: press window.
  task automatic run_cycles(int n, int fd, int bd, int pat, int plen);
    for (int k = 0; k < n; k++) begin
      logic pb, pr, pe;
      pb = busy; pr = run; pe = err;
      step();
      cyc++;
      if (rng_step) rng_q.push_back(cyc);
      if (filt_load) begin load_q.push_back(cyc); fl_at = cyc; end
      if (bcd_start) begin bst_q.push_back(cyc); bs_at = cyc; end
      if (pb && !busy) idle_q.push_back(cyc);
      if (!pr && run) rise_at = cyc;
      if (pr && !run) fall_at = cyc;
      if (!pe && err) err_at = cyc;
      if (page_tick) begin
        ptk_q.push_back(cyc);
        psel_q.push_back(int'(page_sel));
      end
      filt_done = (fd >= 0) && (cyc == fl_at + fd);
      bcd_done = (bd >= 0) && (cyc == bs_at + bd);
      btn = !((pat >= 0) && (cyc >= pat) && (cyc < pat + plen));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn = i[0];
      step();
    end
    n_chk++;
    if ({run, rng_step, filt_load, bcd_start, busy, calc_count,
         page_sel, page_tick, overrun, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: run=%b busy=%b cnt=%0d page=%0d got nonzero, want all 0",
               run, busy, calc_count, page_sel);
    end
    do_reset();
    run_cycles(10, -1, -1, 1, 5);
    n_chk++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_async_run: run=%b want 1", run);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({run, busy, calc_count, page_sel, overrun, err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: run=%b page=%0d want 0", run, page_sel);
    end
  endtask

  task automatic test_button();
    do_reset();
    run_cycles(14, -1, -1, 1, 3);
    n_chk++;
    if (run !== 1'b0 || rise_at != -1) begin
      n_fail++;
      $display("FAIL short_press: run=%b rise=%0d want 0/-1", run, rise_at);
    end
    run_cycles(12, -1, -1, 15, 5);
    n_chk++;
    if (rise_at != 22 || run !== 1'b1) begin
      n_fail++;
      $display("FAIL press_on: rise=%0d run=%b want 22/1", rise_at, run);
    end
    run_cycles(12, -1, -1, -1, 0);
    n_chk++;
    if (run !== 1'b1 || fall_at != -1) begin
      n_fail++;
      $display("FAIL release: run=%b fall=%0d want 1/-1", run, fall_at);
    end
    run_cycles(10, -1, -1, 39, 5);
    n_chk++;
    if (fall_at != 46 || run !== 1'b0) begin
      n_fail++;
      $display("FAIL press_off: fall=%0d run=%b want 46/0", fall_at, run);
    end
  endtask

  task automatic test_single_calc();
    do_reset();
    run_cycles(29, 3, 5, 1, 5);
    n_chk++;
    if (rng_q.size() != 1 || rng_q[0] != 17) begin
      n_fail++;
      $display("FAIL single_rng: n=%0d at=%0d want 1/17", rng_q.size(), rng_q[0]);
    end
    n_chk++;
    if (load_q.size() != 1 || load_q[0] != 18) begin
      n_fail++;
      $display("FAIL single_load: at=%0d want 18", load_q[0]);
    end
    n_chk++;
    if (bst_q.size() != 1 || bst_q[0] != 22) begin
      n_fail++;
      $display("FAIL single_bcd: at=%0d want 22", bst_q[0]);
    end
    n_chk++;
    if (idle_q.size() != 1 || idle_q[0] != 28) begin
      n_fail++;
      $display("FAIL single_idle: at=%0d want 28", idle_q[0]);
    end
    n_chk++;
    if (calc_count !== 8'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cnt: cnt=%0d busy=%b want 1/0", calc_count, busy);
    end
    n_chk++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ovr: overrun=%b want 1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_cycles(38, 1, 1, 1, 5);
    n_chk++;
    if (rng_q.size() != 3 || rng_q[1] != 25 || rng_q[2] != 33) begin
      n_fail++;
      $display("FAIL b2b_rng: n=%0d r1=%0d r2=%0d want 3/25/33",
               rng_q.size(), rng_q[1], rng_q[2]);
    end
    n_chk++;
    if (calc_count !== 8'd3 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_cnt: cnt=%0d ovr=%b want 3/0", calc_count, overrun);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    run_cycles(24, 10, 5, 1, 5);
    n_chk++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_early: overrun=%b want 0", overrun);
    end
    run_cycles(14, 10, 5, -1, 0);
    n_chk++;
    if (overrun !== 1'b1 || calc_count !== 8'd1 || rng_q.size() != 1) begin
      n_fail++;
      $display("FAIL ovr_late: ovr=%b cnt=%0d rng=%0d want 1/1/1",
               overrun, calc_count, rng_q.size());
    end
    n_chk++;
    if (bst_q[0] != 29 || idle_q[0] != 35) begin
      n_fail++;
      $display("FAIL ovr_timing: bcd=%0d idle=%0d want 29/35", bst_q[0], idle_q[0]);
    end
  endtask

  task automatic test_stop();
    do_reset();
    run_cycles(19, 10, 5, 1, 5);
    run_cycles(56, 10, 5, 20, 5);
    n_chk++;
    if (fall_at != 27 || run !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_fall: fall=%0d run=%b want 27/0", fall_at, run);
    end
    n_chk++;
    if (idle_q.size() != 1 || idle_q[0] != 35 || calc_count !== 8'd1) begin
      n_fail++;
      $display("FAIL stop_done: idle=%0d cnt=%0d want 35/1", idle_q[0], calc_count);
    end
    n_chk++;
    if (rng_q.size() != 1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_quiet: rng=%0d ovr=%b want 1/1", rng_q.size(), overrun);
    end
    run_cycles(10, 10, 5, 76, 5);
    n_chk++;
    if (rise_at != 83 || calc_count !== 8'd0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: rise=%0d cnt=%0d ovr=%b want 83/0/0",
               rise_at, calc_count, overrun);
    end
  endtask

  task automatic test_paging();
    int exp_t[4];
    int exp_s[4];
    exp_t = '{16, 32, 48, 64};
    exp_s = '{1, 2, 3, 0};
    do_reset();
    run_cycles(70, -1, -1, 30, 5);
    n_chk++;
    if (ptk_q.size() != 4 || page_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL page_cnt: ticks=%0d page=%0d want 4/0", ptk_q.size(), page_sel);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (ptk_q[i] != exp_t[i] || psel_q[i] != exp_s[i]) begin
        n_fail++;
        $display("FAIL page_%0d: at=%0d sel=%0d want %0d/%0d",
                 i, ptk_q[i], psel_q[i], exp_t[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    run_cycles(50, 0, -1, 1, 5);
    n_chk++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_early: err=%b busy=%b want 0/1", err, busy);
    end
    run_cycles(3, -1, -1, -1, 0);
`ifdef FIR_SEQ_WATCHDOG_EN
    n_chk++;
    if (err_at != 51 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_err: at=%0d err=%b want 51/1", err_at, err);
    end
    n_chk++;
    if (busy !== 1'b0 || calc_count !== 8'd0 || idle_q.size() != 1) begin
      n_fail++;
      $display("FAIL wd_abort: busy=%b cnt=%0d want 0/0", busy, calc_count);
    end
`else
    n_chk++;
    if (err !== 1'b0 || busy !== 1'b1 || calc_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wd_hold: err=%b busy=%b cnt=%0d want 0/1/0", err, busy, calc_count);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    run_cycles(2060, 1, 1, 1, 5);
    n_chk++;
    if (calc_count !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_max: cnt=%0d want 255", calc_count);
    end
    run_cycles(2, 1, 1, -1, 0);
    n_chk++;
    if (calc_count !== 8'd0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_zero: cnt=%0d ovr=%b want 0/0", calc_count, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_button();
    test_single_calc();
    test_back_to_back();
    test_overrun();
    test_stop();
    test_paging();
    test_watchdog();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_run_sequencer.md
Name: fir_run_sequencer

Overview:
Run controller for the FIR/moving-average machine. It debounces the start/stop button and owns the run enable. It generates the sample-rate tick and sequences each calculation: random-sample step, moving-average load, then BCD conversion, each by pulse/done handshake. It also schedules the paged 3-digit display (blank / high / mid / low digit groups) and counts completed calculations.

Parameters:
SAMPLE_DIV, 50000000, CLOCK_50 cycles per sample tick while running (min 2)
DEBOUNCE_CYC, 500000, stable cycles required before a button level is accepted (min 1)
PAGE_DIV, 25000000, CLOCK_50 cycles per display page (min 2)
CNT_W, 36, width of completed-calculation counter
TIMEOUT_CYC, 1024, handshake watchdog limit (used only with FIR_SEQ_WATCHDOG_EN)

Ports:
CLOCK_50  in  1  system clock; the only clock
rst_n  in  1  asynchronous active-low reset
toggle_btn  in  1  raw push button, active-low, asynchronous to CLOCK_50
run  out  1  run enable to the datapath
rng_step  out  1  one-cycle pulse: random generator advances one sample
filt_load  out  1  one-cycle pulse: moving average accepts the new sample
filt_done  in  1  one-cycle pulse: moving average result valid
bcd_start  out  1  one-cycle pulse: start binary-to-BCD conversion
bcd_done  in  1  one-cycle pulse: BCD digits valid
busy  out  1  high while a calculation is in flight
calc_count  out  CNT_W  completed calculations since last start
page_sel  out  2  display page: 0 blank, 1 digits 8..6, 2 digits 5..3, 3 digits 2..0
page_tick  out  1  one-cycle pulse when page_sel advances
overrun  out  1  sticky: a sample tick arrived while busy
err  out  1  sticky: handshake timeout (watchdog builds only)

Behaviour:
- Reset (rst_n low, async): all outputs 0; FSM in IDLE; prescalers, debounce counter and synchronizer cleared; synchronizer presets to the released level (1).
- Button: 2-FF synchronizer, then a debounce counter. A new level is accepted after DEBOUNCE_CYC consecutive cycles at that level. Each accepted 1->0 transition (press) toggles run on the next cycle. Releases never toggle.
- Start (run 0->1): on the same edge, clear calc_count, overrun, err and the sample prescaler.
- Sample tick: the prescaler counts only while run=1. The tick fires when the count reaches SAMPLE_DIV-1, then the prescaler wraps to 0. The first tick occurs SAMPLE_DIV cycles after run rises.
- FSM: IDLE -> STEP -> LOAD -> WAIT_F -> CONV -> WAIT_B -> IDLE.
  - IDLE: on tick, go to STEP.
  - STEP: rng_step=1 for one cycle.
  - LOAD: filt_load=1 for one cycle.
  - WAIT_F: hold until filt_done.
  - CONV: bcd_start=1 for one cycle.
  - WAIT_B: hold until bcd_done; calc_count increments on the exit cycle.
- busy is high in every state except IDLE.
- Latency: tick at cycle T gives rng_step at T+1 and filt_load at T+2. filt_done at F gives bcd_start at F+1. bcd_done at B gives busy=0 and the updated count at B+1.
- done inputs are honoured only in their own WAIT state and ignored elsewhere. filt_done arriving in the same cycle as the LOAD pulse is not seen.
- Tick while busy: the tick is dropped and overrun is set (sticky until next start or reset).
- Stop mid-calculation (run 1->0 while busy): the in-flight calculation completes and is counted. No new ticks occur. The prescaler holds.
- calc_count wraps modulo 2^CNT_W.
- Display: the page prescaler is free-running, independent of run. page_sel steps 0->1->2->3->0 every PAGE_DIV cycles. page_tick pulses in the cycle page_sel changes.

Optional Feature:
FIR_SEQ_WATCHDOG_EN
- Defined: a counter runs in WAIT_F and WAIT_B. If it reaches TIMEOUT_CYC without the matching done, then:
  - err is set (sticky);
  - the FSM returns to IDLE with no count increment;
  - the counter restarts on each WAIT entry.
- Undefined: the WAIT states hold indefinitely and err is tied to 0.

Test Plan:
(Parameters: SAMPLE_DIV=8, DEBOUNCE_CYC=4, PAGE_DIV=16, TIMEOUT_CYC=32.)
1. Reset and button: hold rst_n=0 with glitchy btn -> all outputs 0. Release reset, then hold btn low 3 cycles -> run stays 0. Hold low 4+ cycles -> run=1 one cycle after acceptance. Release, then press again -> run=0.
2. Single calculation: run=1; datapath answers filt_done 3 cycles after filt_load and bcd_done 5 cycles after bcd_start. Expect rng_step at run-rise+9, pulse ordering per latency rule, calc_count=1, busy low after bcd_done.
3. Overrun: filt_done delayed 10 cycles -> second tick dropped, overrun=1, calc_count=1 after completion.
4. Stop mid-calc: press during WAIT_F -> run=0 and the calc still completes (count=1). No rng_step for 40 further cycles. Restart -> count=0, overrun=0.
5. Display paging: free-run 70 cycles -> page_sel sequence 0,1,2,3,0 with page_tick every 16 cycles, regardless of run.
6. Watchdog (FIR_SEQ_WATCHDOG_EN): never assert filt_done -> err=1 32 cycles after WAIT_F entry, FSM back to IDLE, count unchanged. Without the macro -> busy stays 1 and err stays 0.
